// File: rtl/shift_reg_univ.sv
// Universal shift register: bidirectional shift, rotate, arithmetic shift,
// parallel load and clear, with a shift-step frame counter and end-of-frame pulse.
module shift_reg_univ #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic [CNT_W-1:0] cnt,
    output logic             frame_done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             frame_done_nxt;
    logic             shift_step_c;

    // Next register value; en=0 falls through to HOLD behaviour
    always_comb begin
        q_nxt        = q;
        shift_step_c = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: q_nxt = q;
                MODE_SHL: begin
                    q_nxt        = {q[WIDTH-2:0], si};
                    shift_step_c = 1'b1;
                end
                MODE_SHR: begin
                    q_nxt        = {si, q[WIDTH-1:1]};
                    shift_step_c = 1'b1;
                end
                MODE_ROL: begin
                    q_nxt        = {q[WIDTH-2:0], q[WIDTH-1]};
                    shift_step_c = 1'b1;
                end
                MODE_ROR: begin
                    q_nxt        = {q[0], q[WIDTH-1:1]};
                    shift_step_c = 1'b1;
                end
                MODE_LOAD: q_nxt = d;
                MODE_ASR: begin
                    q_nxt        = {q[WIDTH-1], q[WIDTH-1:1]};
                    shift_step_c = 1'b1;
                end
                MODE_CLR: q_nxt = '0;
                default:  q_nxt = q;
            endcase
        end
    end

    // Frame counter: wraps after WIDTH shift steps; LOAD/CLR abandon the frame
    always_comb begin
        cnt_nxt        = cnt;
        frame_done_nxt = 1'b0;
        if (shift_step_c) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt        = '0;
                frame_done_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (en && (mode == MODE_LOAD || mode == MODE_CLR)) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            q          <= q_nxt;
            cnt        <= cnt_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    assign so_l = q[WIDTH-1];
    assign so_r = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios plus randomized
// operations against an arithmetic reference model.
module tb_shift_reg_univ;

    localparam int unsigned W   = 8;
    localparam longint unsigned MOD  = 64'd1 << W;
    localparam longint unsigned HALF = MOD / 2;

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_SHL  = 3'd1;
    localparam logic [2:0] M_SHR  = 3'd2;
    localparam logic [2:0] M_ROL  = 3'd3;
    localparam logic [2:0] M_ROR  = 3'd4;
    localparam logic [2:0] M_LOAD = 3'd5;
    localparam logic [2:0] M_ASR  = 3'd6;
    localparam logic [2:0] M_CLR  = 3'd7;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [2:0]   mode;
    logic         si;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         so_l;
    logic         so_r;
    logic [2:0]   cnt;
    logic         frame_done;

    logic         en4;
    logic [2:0]   mode4;
    logic         si4;
    logic [3:0]   d4;
    logic [3:0]   q4;
    logic         so_l4;
    logic         so_r4;
    logic [1:0]   cnt4;
    logic         frame_done4;

    int n_checks;
    int n_errors;
    string phase;

    longint unsigned mq;
    int              mcnt;
    int              mfd;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .si(si), .d(d),
        .q(q), .so_l(so_l), .so_r(so_r), .cnt(cnt), .frame_done(frame_done)
    );

    shift_reg_univ #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .si(si4), .d(d4),
        .q(q4), .so_l(so_l4), .so_r(so_r4), .cnt(cnt4), .frame_done(frame_done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    // Reference: register treated as an unsigned integer modulo 2^W
    task automatic model_step(input logic e, input logic [2:0] m, input logic s, input logic [W-1:0] dd);
        longint unsigned sv;
        bit shift;
        sv    = longint'(s);
        shift = 1'b0;
        mfd   = 0;
        if (e) begin
            case (m)
                M_SHL:  begin mq = (mq * 2 + sv) % MOD;                   shift = 1'b1; end
                M_SHR:  begin mq = mq / 2 + sv * HALF;                    shift = 1'b1; end
                M_ROL:  begin mq = (mq * 2) % MOD + mq / HALF;            shift = 1'b1; end
                M_ROR:  begin mq = mq / 2 + (mq % 2) * HALF;              shift = 1'b1; end
                M_ASR:  begin mq = mq / 2 + ((mq >= HALF) ? HALF : 64'd0); shift = 1'b1; end
                M_LOAD: begin mq = longint'(dd); mcnt = 0; end
                M_CLR:  begin mq = 0; mcnt = 0; end
                default: ;
            endcase
            if (shift) begin
                mcnt++;
                if (mcnt == int'(W)) begin
                    mcnt = 0;
                    mfd  = 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        mq   = 0;
        mcnt = 0;
        mfd  = 0;
    endtask

    task automatic compare_all();
        check("q", 64'(q), 64'(mq));
        check("cnt", 64'(cnt), 64'(mcnt));
        check("frame_done", 64'(frame_done), 64'(mfd));
        check("so_l", 64'(so_l), (mq >> (W - 1)) & 64'd1);
        check("so_r", 64'(so_r), mq & 64'd1);
    endtask

    // Drive one operation, clock it, and compare the whole output set
    task automatic do_op(input logic e, input logic [2:0] m, input logic s, input logic [W-1:0] dd);
        en   = e;
        mode = m;
        si   = s;
        d    = dd;
        @(posedge clk);
        model_step(e, m, s, dd);
        #1;
        compare_all();
    endtask

    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_q", 64'(q), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        check("rst_fd", 64'(frame_done), 64'd0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic       pat [8];
        logic       exp_sol [8];
        int         pulses;
        logic [2:0] m;
        logic       shift_modes [8];

        n_checks = 0;
        n_errors = 0;
        pat      = '{1, 0, 1, 1, 0, 0, 0, 0};
        exp_sol  = '{0, 0, 0, 1, 0, 1, 1, 0};
        shift_modes = '{0, 1, 1, 1, 1, 0, 1, 0};

        en = 1'b0; mode = M_HOLD; si = 1'b0; d = '0;
        en4 = 1'b0; mode4 = M_HOLD; si4 = 1'b0; d4 = '0;
        rst_n = 1'b1;
        model_reset();

        phase = "reset";
        #1 rst_n = 1'b0;
        #2;
        compare_all();
        check("q4", 64'(q4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;

        phase = "legacy4";
        for (int k = 0; k < 8; k++) begin
            en4 = 1'b1; mode4 = M_SHL; si4 = pat[k];
            @(posedge clk);
            #1;
            check("so_l", 64'(so_l4), 64'(exp_sol[k]));
            check("frame_done", 64'(frame_done4), (k == 3 || k == 7) ? 64'd1 : 64'd0);
        end
        en4 = 1'b0;
        check("q", 64'(q4), 64'd0);
        check("cnt", 64'(cnt4), 64'd0);
        check("so_r", 64'(so_r4), 64'd0);

        phase = "rotate";
        do_op(1'b1, M_LOAD, 1'b0, 8'hA5);
        do_op(1'b1, M_ROL, 1'b0, 8'h00);
        check("q_rol", 64'(q), 64'h4B);
        do_op(1'b1, M_ROR, 1'b0, 8'h00);
        do_op(1'b1, M_ROR, 1'b0, 8'h00);
        check("q_ror", 64'(q), 64'hD2);
        check("cnt3", 64'(cnt), 64'd3);

        phase = "asr_shr";
        do_op(1'b1, M_LOAD, 1'b0, 8'h90);
        for (int i = 0; i < 3; i++) do_op(1'b1, M_ASR, 1'b1, 8'h00);
        check("q_asr", 64'(q), 64'hF2);
        do_op(1'b1, M_LOAD, 1'b0, 8'h90);
        for (int i = 0; i < 3; i++) do_op(1'b1, M_SHR, 1'b0, 8'h00);
        check("q_shr", 64'(q), 64'h12);

        phase = "enable";
        do_op(1'b1, M_LOAD, 1'b0, 8'h3C);
        for (int i = 0; i < 5; i++) do_op(1'b0, M_SHL, 1'b1, W'($urandom));
        check("q_held", 64'(q), 64'h3C);
        check("cnt_held", 64'(cnt), 64'd0);

        phase = "abort";
        for (int i = 0; i < 6; i++) do_op(1'b1, M_SHL, 1'($urandom), 8'h00);
        check("cnt6", 64'(cnt), 64'd6);
        do_op(1'b1, M_CLR, 1'b1, 8'hFF);
        check("q_clr", 64'(q), 64'd0);
        check("cnt_clr", 64'(cnt), 64'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            do_op(1'b1, M_SHR, 1'($urandom), 8'h00);
            pulses += int'(frame_done);
        end
        check("pulses", 64'(pulses), 64'd1);
        check("fd_after_8th", 64'(frame_done), 64'd1);
        do_op(1'b1, M_HOLD, 1'b0, 8'h00);

        phase = "async_rst";
        for (int i = 0; i < 5; i++) do_op(1'b1, M_SHL, 1'b1, 8'h00);
        async_reset_pulse();
        do_op(1'b1, M_SHL, 1'b1, 8'h00);
        check("q_after", 64'(q), 64'h01);
        check("cnt_after", 64'(cnt), 64'd1);

        phase = "random";
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                do begin
                    m = 3'($urandom_range(0, 7));
                end while (!shift_modes[m]);
            end else begin
                m = 3'($urandom_range(0, 7));
            end
            do_op(($urandom_range(0, 7) != 0), m, 1'($urandom), W'($urandom));
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
